// File: rtl/uart_pkg.sv
// Shared constants, state encoding and character helpers for the UART
// console transmit and receive paths.
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int CLK_DIV_DEFAULT = 868;

    // Response buffer geometry
    localparam int BUF_DEPTH = 6;
    localparam int IDX_W     = 3;
    localparam logic [IDX_W-1:0] RD_LINE_LEN  = 3'd3;
    localparam logic [IDX_W-1:0] ERR_LINE_LEN = 3'd6;

    // ASCII constants shared with the command decoder
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_O    = 8'h4F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Lowercase hex digit, matching the command syntax accepted on receive
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = ASCII_0 + {4'h0, nib};
        end else begin
            res = ASCII_A_LC + {4'h0, nib - 4'd10};
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..CLK_DIV-1 while enabled and emits a
// one-cycle tick at terminal count. Held at zero while disabled. The load
// input lets the receiver start mid-bit by preloading half a period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int PRELOAD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(PRELOAD);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == TERM);

    // Period counter: cleared when idle, wraps to zero on the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Response transmitter: formats a read byte as "hh\n" or the fixed
// "ERROR\n" line and sends it as back-to-back 8N1 frames.
//
//   state | meaning
//   IDLE  | line high, waiting for a request
//   START | start bit (0) for one bit period
//   DATA  | data bits, LSB first, one bit period each
//   STOP  | stop bit (1); then next char or back to IDLE with done
module uart_resp_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_vld,
    input  logic [7:0] rd_data,
    input  logic       err_vld,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    uart_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q;
    logic [2:0]       bit_q, bit_d;
    logic             done_q, done_d;
    logic             load;
    logic             tick;
    logic             tx_c;
    logic [7:0]       cur_char;
    logic [7:0]       buf_q [BUF_DEPTH];

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV),
        .PRELOAD (0)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .load (1'b0),
        .tick (tick)
    );

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign tx   = tx_c;

    // Character currently on the wire
    always_comb begin
        cur_char = buf_q[idx_q];
    end

    // Next-state, counter updates and line level
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        load    = 1'b0;
        tx_c    = 1'b1;
        case (state_q)
            IDLE: begin
                tx_c = 1'b1;
                if (rd_vld || err_vld) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_c = 1'b0;
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_c = cur_char[bit_q];
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_c = 1'b1;
                if (tick) begin
                    if (idx_q == len_q - 3'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, char index, bit index and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
        end
    end

    // Line buffer, loaded once at acceptance; error takes priority over read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            len_q <= '0;
        end else if (load) begin
            if (err_vld) begin
                buf_q[0] <= ASCII_E;
                buf_q[1] <= ASCII_R;
                buf_q[2] <= ASCII_R;
                buf_q[3] <= ASCII_O;
                buf_q[4] <= ASCII_R;
                buf_q[5] <= ASCII_LF;
                len_q    <= ERR_LINE_LEN;
            end else begin
                buf_q[0] <= nib2ascii(rd_data[7:4]);
                buf_q[1] <= nib2ascii(rd_data[3:0]);
                buf_q[2] <= ASCII_LF;
                buf_q[3] <= '0;
                buf_q[4] <= '0;
                buf_q[5] <= '0;
                len_q    <= RD_LINE_LEN;
            end
        end
    end

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx with CLK_DIV=4 and a mid-bit sampling
// receiver. Inputs change and outputs are sampled on the falling edge.
module tb_uart_resp_tx;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       rd_vld;
    logic [7:0] rd_data;
    logic       err_vld;
    logic       busy;
    logic       done;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    uart_resp_tx #(.CLK_DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .err_vld (err_vld),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starting at the first start-bit cycle (or waiting for it), sample each
    // bit at offset 2 of its period; returns at the cycle after the stop bit.
    task automatic rx_char(output logic [7:0] c, output int waited, output logic stop_bit);
        waited = 0;
        c = '0;
        while (tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            c[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        stop_bit = tx;
        repeat (2) @(negedge clk);
    endtask

    // Receive n back-to-back chars; exp holds char 0 in its top used byte
    task automatic rx_line(input string tag, input int n, input logic [47:0] exp);
        logic [7:0] c;
        int         w;
        logic       s;
        for (int i = 0; i < n; i++) begin
            rx_char(c, w, s);
            chk($sformatf("%s_char%0d", tag, i), {24'h0, c}, {24'h0, exp[8*(n-1-i) +: 8]});
            chk($sformatf("%s_gap%0d", tag, i), w, 0);
            chk($sformatf("%s_stop%0d", tag, i), {31'h0, s}, 32'h1);
        end
    endtask

    task automatic request(input logic rd, input logic err, input logic [7:0] d);
        rd_vld  = rd;
        err_vld = err;
        rd_data = d;
        @(negedge clk);
        rd_vld  = 1'b0;
        err_vld = 1'b0;
        rd_data = 8'h00;
    endtask

    initial begin
        int b0, d0, zeros;
        rst     = 1'b1;
        rd_vld  = 1'b0;
        err_vld = 1'b0;
        rd_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx", {31'h0, tx}, 32'h1);

        // Read 0xF0 -> "f0\n"
        b0 = busy_cnt;
        d0 = done_cnt;
        request(1'b1, 1'b0, 8'hF0);
        chk("f0_start_tx", {31'h0, tx}, 32'h0);
        chk("f0_start_busy", {31'h0, busy}, 32'h1);
        rx_line("f0", 3, {24'h0, 8'h66, 8'h30, 8'h0A});
        chk("f0_done", {31'h0, done}, 32'h1);
        chk("f0_busy_fall", {31'h0, busy}, 32'h0);
        chk("f0_busy_cycles", busy_cnt - b0, 120);
        @(negedge clk);
        chk("f0_done_one", {31'h0, done}, 32'h0);
        chk("f0_done_count", done_cnt - d0, 1);

        // Read 0x09 -> "09\n", start bit right after the request cycle
        repeat (3) @(negedge clk);
        rd_vld  = 1'b1;
        rd_data = 8'h09;
        chk("09_req_cycle_tx", {31'h0, tx}, 32'h1);
        chk("09_req_cycle_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rd_vld  = 1'b0;
        rd_data = 8'h00;
        chk("09_t1_tx", {31'h0, tx}, 32'h0);
        rx_line("09", 3, {24'h0, 8'h30, 8'h39, 8'h0A});
        chk("09_done", {31'h0, done}, 32'h1);

        // Error line
        repeat (3) @(negedge clk);
        b0 = busy_cnt;
        d0 = done_cnt;
        request(1'b0, 1'b1, 8'h00);
        rx_line("err", 6, {8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0A});
        chk("err_done", {31'h0, done}, 32'h1);
        chk("err_busy_cycles", busy_cnt - b0, 240);
        @(negedge clk);
        chk("err_done_count", done_cnt - d0, 1);

        // Simultaneous read+error: error wins; read during busy dropped
        repeat (3) @(negedge clk);
        b0 = busy_cnt;
        request(1'b1, 1'b1, 8'h5A);
        fork
            rx_line("both", 6, {8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0A});
            begin
                repeat (49) @(negedge clk);
                rd_vld  = 1'b1;
                rd_data = 8'h33;
                @(negedge clk);
                rd_vld  = 1'b0;
                rd_data = 8'h00;
            end
        join
        chk("both_done", {31'h0, done}, 32'h1);
        chk("both_busy_cycles", busy_cnt - b0, 240);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) zeros++;
        end
        chk("both_no_extra", zeros, 0);

        // Reset during DATA bit 3 of char 1 ("3c\n", 'c'=0x63 has bit3=0)
        d0 = done_cnt;
        request(1'b1, 1'b0, 8'h3C);
        repeat (57) @(negedge clk);
        chk("rst_mid_tx_before", {31'h0, tx}, 32'h0);
        chk("rst_mid_busy_before", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", {31'h0, tx}, 32'h1);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        request(1'b1, 1'b0, 8'hA1);
        rx_line("a1", 3, {24'h0, 8'h61, 8'h31, 8'h0A});
        chk("a1_done", {31'h0, done}, 32'h1);

        // Back-to-back: new request in the done cycle
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        request(1'b1, 1'b0, 8'h12);
        rx_line("b2b1", 3, {24'h0, 8'h31, 8'h32, 8'h0A});
        chk("b2b_done", {31'h0, done}, 32'h1);
        chk("b2b_done_tx", {31'h0, tx}, 32'h1);
        request(1'b1, 1'b0, 8'hB7);
        chk("b2b_accept_tx", {31'h0, tx}, 32'h0);
        chk("b2b_accept_busy", {31'h0, busy}, 32'h1);
        rx_line("b2b2", 3, {24'h0, 8'h62, 8'h37, 8'h0A});
        chk("b2b2_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
